// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined binary<->Gray converter with valid/ready flow
// control and a single-step checker on Gray (decode) inputs.
//
// Every transaction carries its own mode, partially converted word and
// sequence-error bit down a STAGES-deep register pipeline. Encode needs only
// one XOR level, so it is done entirely in the first stage and later stages
// pass the word through. Decode is a prefix-XOR chain from the MSB down. That
// chain is cut into ceil(WIDTH/STAGES)-bit slices, and stage s resolves slice s.
// A partial word therefore holds binary bits above the current slice and
// untouched Gray bits below it.
module gray_codec_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_seq_err
);

  // Bits of the decode chain resolved per stage, MSB slice first.
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic             stg_valid [STAGES];
  logic             stg_mode  [STAGES];
  logic             stg_err   [STAGES];
  logic [WIDTH-1:0] stg_data  [STAGES];
  logic [WIDTH-1:0] nxt_data  [STAGES];

  logic [WIDTH-1:0] last_gray;
  logic             hist_valid;
  logic             stall;
  logic             accept;
  logic             seq_err_in;

  // Resolve the decode slice owned by 'stage'. Bits above the slice are already
  // binary, so each bit in the slice XORs its Gray bit with the binary bit just
  // above it, walking downward. The MSB never changes.
  function automatic logic [WIDTH-1:0] resolve_chunk(input logic [WIDTH-1:0] word,
                                                     input int stage);
    logic [WIDTH-1:0] res;
    int hi;
    int lo;
    res = word;
    hi  = WIDTH - 1 - stage * CHUNK;
    lo  = hi - CHUNK + 1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) begin
        res[i] = res[i+1] ^ res[i];
      end
    end
    return res;
  endfunction

  // A full output that the consumer refuses freezes the whole pipe.
  // Otherwise everything, bubbles included, moves one stage per cycle.
  assign stall    = stg_valid[STAGES-1] && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // A decode input is flagged when a previous decode exists and the Hamming
  // distance to it is anything other than exactly one bit.
  assign seq_err_in = !in_mode && hist_valid && ($countones(in_data ^ last_gray) != 1);

  // Next-stage word for every stage. Encode is finished at entry. Decode
  // resolves one slice per stage.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      nxt_data[s] = '0;
    end
    nxt_data[0] = in_mode ? (in_data ^ (in_data >> 1)) : resolve_chunk(in_data, 0);
    for (int s = 1; s < STAGES; s++) begin
      nxt_data[s] = stg_mode[s-1] ? stg_data[s-1] : resolve_chunk(stg_data[s-1], s);
    end
  end

  // Pipeline registers. Payload is loaded only with a valid transaction, so
  // the output word keeps its last value while bubbles pass through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_valid[s] <= 1'b0;
        stg_mode[s]  <= 1'b0;
        stg_err[s]   <= 1'b0;
        stg_data[s]  <= '0;
      end
    end else if (!stall) begin
      stg_valid[0] <= accept;
      if (accept) begin
        stg_mode[0] <= in_mode;
        stg_err[0]  <= seq_err_in;
        stg_data[0] <= nxt_data[0];
      end
      for (int s = 1; s < STAGES; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        if (stg_valid[s-1]) begin
          stg_mode[s] <= stg_mode[s-1];
          stg_err[s]  <= stg_err[s-1];
          stg_data[s] <= nxt_data[s];
        end
      end
    end
  end

  // Decode history for the sequence checker. Encodes leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gray  <= '0;
      hist_valid <= 1'b0;
    end else if (accept && !in_mode) begin
      last_gray  <= in_data;
      hist_valid <= 1'b1;
    end
  end

  assign out_valid   = stg_valid[STAGES-1];
  assign out_mode    = stg_mode[STAGES-1];
  assign out_seq_err = stg_err[STAGES-1];
  assign out_data    = stg_data[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: directed checks of the default 4-bit/2-stage converter
// plus a width/depth sweep against an independent reference model.
module tb_gray_codec_pipe;

  localparam int STG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WIDTH=4, STAGES=2)
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_mode;
  logic [3:0] out_data;
  logic       out_seq_err;

  gray_codec_pipe #(.WIDTH(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .out_seq_err(out_seq_err)
  );

  // Sweep DUTs, driven by a shared valid, mode and source word
  logic        sw_valid;
  logic        sw_mode;
  logic        sw_ready;
  logic [12:0] sw_word;

  logic        a_ready, a_valid, a_mode, a_err;
  logic [1:0]  a_data;
  logic        b_ready, b_valid, b_mode, b_err;
  logic [7:0]  b_data;
  logic        c_ready, c_valid, c_mode, c_err;
  logic [12:0] c_data;

  gray_codec_pipe #(.WIDTH(2), .STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(a_ready), .in_mode(sw_mode), .in_data(sw_word[1:0]),
    .out_valid(a_valid), .out_ready(sw_ready), .out_mode(a_mode),
    .out_data(a_data), .out_seq_err(a_err)
  );

  gray_codec_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(b_ready), .in_mode(sw_mode), .in_data(sw_word[7:0]),
    .out_valid(b_valid), .out_ready(sw_ready), .out_mode(b_mode),
    .out_data(b_data), .out_seq_err(b_err)
  );

  gray_codec_pipe #(.WIDTH(13), .STAGES(13)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(c_ready), .in_mode(sw_mode), .in_data(sw_word),
    .out_valid(c_valid), .out_ready(sw_ready), .out_mode(c_mode),
    .out_data(c_data), .out_seq_err(c_err)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Log of words consumed from the main DUT
  logic [3:0] got_data[$];
  logic       got_mode[$];
  logic       got_err[$];
  int         got_cyc[$];

  logic [3:0] stim_data[$];
  logic       stim_mode[$];

  // Record a consumption that happens on the coming edge, then advance one cycle
  task automatic step;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_data.push_back(out_data);
      got_mode.push_back(out_mode);
      got_err.push_back(out_seq_err);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log;
    got_data.delete();
    got_mode.delete();
    got_err.delete();
    got_cyc.delete();
    cyc = 0;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Present the stim queues back to back with out_ready high, then drain
  task automatic run_stream;
    int n;
    n = stim_data.size();
    for (int i = 0; i < n + STG + 1; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_mode  = stim_mode[i];
        in_data  = stim_data[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Independent reference: decode bit i is the XOR of all Gray bits at and above i
  function automatic logic [12:0] ref_conv(input logic [12:0] w, input int width, input logic mode);
    logic [12:0] m;
    logic [12:0] v;
    logic [12:0] r;
    m = (13'h1 << width) - 13'h1;
    v = w & m;
    r = '0;
    if (mode) begin
      r = v ^ (v >> 1);
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (i < width) r[i] = ^(v >> i);
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    sw_mode   = 1'b0;
    sw_word   = '0;
    sw_ready  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if (out_data !== 4'h0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
    else passed++;
    checks++;
    if (out_mode !== 1'b0 || out_seq_err !== 1'b0)
      $display("[TB] FAIL reset_mode_err: got mode %b err %b expected 0 0", out_mode, out_seq_err);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_gray_sequence;
    clear_log();
    stim_data = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    stim_mode = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stream();
    checks++;
    if (got_data.size() != 16) $display("[TB] FAIL seq16_count: got %0d words expected 16", got_data.size());
    else passed++;
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      checks++;
      if (got_data[i] !== 4'(i)) $display("[TB] FAIL seq16_data[%0d]: got %h expected %h", i, got_data[i], 4'(i));
      else passed++;
      checks++;
      if (got_err[i] !== 1'b0 || got_mode[i] !== 1'b0)
        $display("[TB] FAIL seq16_flags[%0d]: got err %b mode %b expected 0 0", i, got_err[i], got_mode[i]);
      else passed++;
      checks++;
      if (got_cyc[i] != i + STG) $display("[TB] FAIL seq16_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], i + STG);
      else passed++;
    end
  endtask

  task automatic test_encode_decode;
    logic [3:0] exp_data[$];
    logic       exp_err[$];
    clear_log();
    stim_data = '{4'b1011, 4'b1101, 4'b0011, 4'b0110, 4'b1000, 4'b0111};
    stim_mode = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
    exp_data  = '{4'b1110, 4'b1001, 4'b0010, 4'b0100, 4'b1100, 4'b0101};
    // last decode before this was 1000: 1101 is 2 steps away, 0110 is 3 from 1101
    exp_err   = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    run_stream();
    checks++;
    if (got_data.size() != 6) $display("[TB] FAIL mixed_count: got %0d words expected 6", got_data.size());
    else passed++;
    for (int i = 0; i < got_data.size() && i < 6; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i]) $display("[TB] FAIL mixed_data[%0d]: got %b expected %b", i, got_data[i], exp_data[i]);
      else passed++;
      checks++;
      if (got_mode[i] !== stim_mode[i]) $display("[TB] FAIL mixed_mode[%0d]: got %b expected %b", i, got_mode[i], stim_mode[i]);
      else passed++;
      checks++;
      if (got_err[i] !== exp_err[i]) $display("[TB] FAIL mixed_err[%0d]: got %b expected %b", i, got_err[i], exp_err[i]);
      else passed++;
    end
  endtask

  task automatic test_seq_errors;
    logic [3:0] exp_data[$];
    logic       exp_err[$];
    apply_reset();
    clear_log();
    stim_data = '{4'b0000, 4'b0011, 4'b0101, 4'b1111, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    stim_mode = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
    exp_data  = '{4'b0000, 4'b0010, 4'b0110, 4'b1000, 4'b0111, 4'b1111, 4'b0000, 4'b0000};
    exp_err   = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
    run_stream();
    checks++;
    if (got_data.size() != 8) $display("[TB] FAIL seqerr_count: got %0d words expected 8", got_data.size());
    else passed++;
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      checks++;
      if (got_err[i] !== exp_err[i]) $display("[TB] FAIL seqerr_flag[%0d]: got %b expected %b", i, got_err[i], exp_err[i]);
      else passed++;
      checks++;
      if (got_data[i] !== exp_data[i]) $display("[TB] FAIL seqerr_data[%0d]: got %b expected %b", i, got_data[i], exp_data[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] items[$];
    clear_log();
    items     = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    out_ready = 1'b1;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    in_data   = items[0];
    step();
    in_data = items[1];
    step();
    in_data   = items[2];
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready_start: got %b expected 0", in_ready);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd3)
        $display("[TB] FAIL bp_hold[%0d]: got valid %b data %h expected 1 3", k, out_valid, out_data);
      else passed++;
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready);
      else passed++;
    end
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      in_data = items[i];
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (got_data.size() != 6) $display("[TB] FAIL bp_count: got %0d words expected 6", got_data.size());
    else passed++;
    for (int i = 0; i < got_data.size() && i < 6; i++) begin
      checks++;
      if (got_data[i] !== 4'(i + 3) || got_err[i] !== 1'b0)
        $display("[TB] FAIL bp_data[%0d]: got %h err %b expected %h err 0", i, got_data[i], got_err[i], 4'(i + 3));
      else passed++;
    end
  endtask

  task automatic test_reset_midstream;
    clear_log();
    out_ready = 1'b1;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b1101;
    step();
    in_data = 4'b1100;
    step();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
    else passed++;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (got_data.size() != 0) $display("[TB] FAIL midrst_leak: got %0d words expected 0", got_data.size());
    else passed++;
    clear_log();
    stim_data = '{4'b1111};
    stim_mode = '{1'b0};
    run_stream();
    checks++;
    if (got_data.size() != 1) $display("[TB] FAIL midrst_count: got %0d words expected 1", got_data.size());
    else passed++;
    if (got_data.size() == 1) begin
      checks++;
      if (got_data[0] !== 4'b1010 || got_err[0] !== 1'b0 || got_cyc[0] != STG)
        $display("[TB] FAIL midrst_after: got %b err %b cycle %0d expected 1010 err 0 cycle %0d",
                 got_data[0], got_err[0], got_cyc[0], STG);
      else passed++;
    end
  endtask

  task automatic test_sweep;
    logic [12:0] exp_a, exp_b, exp_c;
    logic [12:0] r;
    int lat_a, lat_b, lat_c;
    logic [1:0]  da;
    logic [7:0]  db;
    logic [12:0] dc;
    logic ma, mb, mc, ea, eb, ec;
    for (int t = 0; t < 12; t++) begin
      r = 13'($urandom);
      if (t == 0) r = 13'h0000;
      if (t == 1) r = 13'h1FFF;
      sw_word  = r;
      sw_mode  = t[0];
      sw_valid = 1'b1;
      exp_a = ref_conv(r, 2, sw_mode);
      exp_b = ref_conv(r, 8, sw_mode);
      exp_c = ref_conv(r, 13, sw_mode);
      #1;
      checks++;
      if ({a_ready, b_ready, c_ready} !== 3'b111)
        $display("[TB] FAIL sweep_ready[%0d]: got %b expected 111", t, {a_ready, b_ready, c_ready});
      else passed++;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      lat_a = 0; lat_b = 0; lat_c = 0;
      da = '0; db = '0; dc = '0;
      ma = 1'b0; mb = 1'b0; mc = 1'b0; ea = 1'b0; eb = 1'b0; ec = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (a_valid === 1'b1 && lat_a == 0) begin lat_a = c; da = a_data; ma = a_mode; ea = a_err; end
        if (b_valid === 1'b1 && lat_b == 0) begin lat_b = c; db = b_data; mb = b_mode; eb = b_err; end
        if (c_valid === 1'b1 && lat_c == 0) begin lat_c = c; dc = c_data; mc = c_mode; ec = c_err; end
        @(posedge clk); #1;
      end
      checks++;
      if (lat_a != 1 || da !== exp_a[1:0])
        $display("[TB] FAIL sweep_w2s1[%0d]: got %b lat %0d expected %b lat 1", t, da, lat_a, exp_a[1:0]);
      else passed++;
      checks++;
      if (lat_b != 3 || db !== exp_b[7:0])
        $display("[TB] FAIL sweep_w8s3[%0d]: got %h lat %0d expected %h lat 3", t, db, lat_b, exp_b[7:0]);
      else passed++;
      checks++;
      if (lat_c != 13 || dc !== exp_c)
        $display("[TB] FAIL sweep_w13s13[%0d]: got %h lat %0d expected %h lat 13", t, dc, lat_c, exp_c);
      else passed++;
      checks++;
      if ({ma, mb, mc} !== {3{sw_mode}})
        $display("[TB] FAIL sweep_mode[%0d]: got %b expected %b", t, {ma, mb, mc}, {3{sw_mode}});
      else passed++;
      if (sw_mode) begin
        checks++;
        if ({ea, eb, ec} !== 3'b000) $display("[TB] FAIL sweep_enc_err[%0d]: got %b expected 000", t, {ea, eb, ec});
        else passed++;
      end
    end
  endtask

  // Sequence the scenarios and report
  initial begin
    test_reset();
    test_gray_sequence();
    test_encode_decode();
    test_seq_errors();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Guard against a hang if the DUT wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Parametrised, pipelined Gray-code converter. Each transaction selects encode (binary→Gray) or decode (Gray→binary) and carries a WIDTH-bit data word.
- Successor to the fixed 4-bit combinational Gray decoder: arbitrary width, both directions, registered pipeline with valid/ready backpressure.
- Adds a Gray sequence checker that flags decode inputs that are not single-bit steps from the previous decode input.
- Sits between a position/pointer source (e.g. Gray-coded counter or CDC pointer) and binary consumers.

Parameters:
- WIDTH, 4, data width in bits (≥2).
- STAGES, 2, pipeline register stages (1..WIDTH); equals latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept input this cycle.
- in_mode  input  1  0 = decode (Gray→binary), 1 = encode (binary→Gray).
- in_data  input  WIDTH  code word to convert.
- out_valid  output  1  output transaction valid.
- out_ready  input  1  consumer accepts output this cycle.
- out_mode  output  1  mode of the transaction at the output.
- out_data  output  WIDTH  converted word.
- out_seq_err  output  1  sequence-error flag for this output transaction (decode only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_mode=0, out_seq_err=0, all internal stage valids=0, history-valid=0. in_ready=1 on the first cycle after reset is released.
- Accept and stall:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall, combinational.
  - When stalled, every stage holds its contents. Otherwise all stages advance one position per cycle; bubbles (valid=0) advance too.
- Latency: an accepted input appears at the output exactly STAGES cycles later, provided there is no stall. Throughput is one word per cycle. Ordering is strictly in order.
- Encode: g = b ^ (b >> 1).
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - The prefix-XOR chain is split across the STAGES registers. Each stage resolves ceil(WIDTH/STAGES) bits, MSB first.
  - Partial results and mode travel with the data.
  - The result must be bit-exact for every WIDTH/STAGES combination.
- Sequence checker (decode transactions only):
  - On each accepted decode input: if history-valid and popcount(in_data ^ last_gray) != 1, the transaction's seq_err bit is set.
  - last_gray <= in_data; history-valid <= 1.
  - The first decode after reset never flags.
  - Repeated identical input (distance 0) flags.
  - Wrap-around (e.g. 1000→0000 at WIDTH=4) is distance 1 and does not flag.
  - Encode transactions never flag and do not update last_gray or history-valid.
  - seq_err rides the pipeline and is presented as out_seq_err with its own transaction.
- Output hold: out_data, out_mode and out_seq_err are stable while stalled. When out_valid=0 they hold their last values (don't-care for checking).
- Simultaneous events: accept and consume in the same cycle are legal and give full throughput. in_valid is ignored while in_ready=0.
- Reset mid-operation: all in-flight transactions are discarded and history is cleared. No output may appear from pre-reset inputs.

Test Plan:
- Defaults (WIDTH=4, STAGES=2), out_ready=1; decode the full 16-entry Gray sequence 0000,0001,0011,…,1000 → out_data 0..15 in order, first out_valid exactly 2 cycles after first accept, out_seq_err=0 throughout.
- Encode 4'b1011 → 4'b1110; decode 4'b1101 → 4'b1001; mixed back-to-back modes → out_mode tracks each transaction.
- Sequence errors:
  - decode 0000 then 0011 → second output has out_seq_err=1;
  - decode 0101, then encode 1111, then decode 0100 → seq_err=0 (encode ignored);
  - decode 1000 then 0000 → seq_err=0 (wrap).
- Backpressure: stream 6 decodes, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 during the stall, out_data/out_valid stable, no loss or duplication, order preserved.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 transactions in flight → out_valid=0 next cycle, nothing emitted. The next decode after reset, 1111, gives out_data 1010 with seq_err=0.
- Sweep WIDTH∈{2,8,13}, STAGES∈{1,3,WIDTH}: random words both modes vs. reference model → bit-exact data, latency = STAGES.
